// File: rtl/eth_rx_ring.sv
// Receive frame ring: filters byte-wide AXIS on destination MAC, stores frames in NBUF slots, CPU register file.
// Writes are combinational with the input byte, register reads return one cycle later; no backpressure, full ring drops whole frames.
module eth_rx_ring #(
    parameter int          NBUF      = 8,
    parameter int          BUF_AW    = 11,
    parameter logic [47:0] MAC_RESET = 48'h230100890702
) (
    input  logic                           msoc_clk,
    input  logic                           rst_int,
    input  logic [7:0]                     rx_tdata,
    input  logic                           rx_tvalid,
    input  logic                           rx_tlast,
    input  logic                           rx_tuser,
    output logic                           mem_we,
    output logic [$clog2(NBUF)+BUF_AW-1:0] mem_addr,
    output logic [7:0]                     mem_wdata,
    input  logic                           reg_sel,
    input  logic                           reg_we,
    input  logic [2:0]                     reg_addr,
    input  logic [31:0]                    reg_wdata,
    output logic [31:0]                    reg_rdata,
    output logic                           irq
);
    localparam int SW = $clog2(NBUF);
    localparam int CW = SW + 1;
    localparam int LW = BUF_AW + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]    r_state;
    logic [SW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [LW-1:0] r_off;
    logic [47:0]   r_dst, r_mac;
    logic          r_irq_en, r_promisc, r_irq;
    logic [15:0]   r_err_cnt, r_flt_cnt, r_ovf_cnt;
    logic [LW-1:0] r_len [NBUF];
    logic [31:0]   r_rdata;

    logic [1:0]    w_state_nxt;
    logic [LW-1:0] w_off_nxt;
    logic          w_commit, w_err_inc, w_flt_inc, w_ovf_inc;
    logic          w_full, w_match, w_ovfl, w_we, w_wr, w_release, w_clr;
    logic [47:0]   w_dst_next;
    logic [LW-1:0] w_len_tail;
    logic [31:0]   w_rd;

    function automatic logic [15:0] bump(input logic [15:0] c, input logic inc, input logic clr);
        if (clr)
            return 16'h0;
        else if (inc && c != 16'hFFFF)
            return c + 16'h1;
        else
            return c;
    endfunction

    assign w_full     = (r_count == CW'(NBUF));
    assign w_dst_next = {r_dst[39:0], rx_tdata};
    assign w_match    = r_promisc || (&w_dst_next) || (w_dst_next[47:24] == 24'h01005E) ||
                        (w_dst_next == r_mac);
    // Offset MSB set means the slot is already full of bytes.
    assign w_ovfl     = r_off[BUF_AW];
    assign w_we       = !rst_int && rx_tvalid &&
                        ((r_state == S_IDLE && !w_full) || r_state == S_HDR ||
                         (r_state == S_BODY && !w_ovfl));
    assign mem_we     = w_we;
    assign mem_addr   = {r_head, r_off[BUF_AW-1:0]};
    assign mem_wdata  = w_we ? rx_tdata : 8'h00;

    assign w_wr       = reg_sel && reg_we;
    assign w_release  = w_wr && reg_addr == 3'd3 && r_count != '0;
    assign w_clr      = w_wr && reg_addr == 3'd4;
    assign w_len_tail = (r_count != '0) ? r_len[r_tail] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_off;
        w_commit    = 1'b0;
        w_err_inc   = 1'b0;
        w_flt_inc   = 1'b0;
        w_ovf_inc   = 1'b0;
        if (rx_tvalid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_full) begin
                        w_ovf_inc = 1'b1;
                        if (!rx_tlast) w_state_nxt = S_DROP;
                    end else if (rx_tlast) begin
                        w_err_inc = 1'b1;
                    end else begin
                        w_off_nxt   = LW'(1);
                        w_state_nxt = S_HDR;
                    end
                end
                S_HDR: begin
                    w_off_nxt = r_off + LW'(1);
                    if (r_off == LW'(5)) begin
                        if (!w_match) begin
                            w_flt_inc   = 1'b1;
                            w_off_nxt   = '0;
                            w_state_nxt = rx_tlast ? S_IDLE : S_DROP;
                        end else if (rx_tlast) begin
                            w_commit    = !rx_tuser;
                            w_err_inc   = rx_tuser;
                            w_off_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_BODY;
                        end
                    end else if (rx_tlast) begin
                        w_err_inc   = 1'b1;
                        w_off_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BODY: begin
                    w_off_nxt = r_off + LW'(1);
                    if (w_ovfl) begin
                        w_err_inc   = 1'b1;
                        w_off_nxt   = '0;
                        w_state_nxt = rx_tlast ? S_IDLE : S_DROP;
                    end else if (rx_tlast) begin
                        w_commit    = !rx_tuser;
                        w_err_inc   = rx_tuser;
                        w_off_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    if (rx_tlast) w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rd = 32'h0;
        case (reg_addr)
            3'd0: w_rd = r_mac[31:0];
            3'd1: w_rd = {r_irq_en, r_promisc, 14'h0, r_mac[47:32]};
            3'd2: w_rd = {8'h0, 8'(r_count), 8'(r_head), 8'(r_tail)};
            3'd4: w_rd = {r_err_cnt, r_flt_cnt};
            3'd5: w_rd = {r_ovf_cnt, 16'(w_len_tail)};
            default: w_rd = 32'h0;
        endcase
    end

    always_ff @(posedge msoc_clk or posedge rst_int) begin
        if (rst_int) begin
            r_state   <= S_IDLE;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_off     <= '0;
            r_dst     <= '0;
            r_mac     <= MAC_RESET;
            r_irq_en  <= 1'b0;
            r_promisc <= 1'b0;
            r_irq     <= 1'b0;
            r_err_cnt <= '0;
            r_flt_cnt <= '0;
            r_ovf_cnt <= '0;
            r_rdata   <= '0;
            for (int i = 0; i < NBUF; i++) r_len[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_off   <= w_off_nxt;
            if (rx_tvalid && (r_state == S_IDLE || r_state == S_HDR)) r_dst <= w_dst_next;
            if (w_commit) begin
                r_len[r_head] <= r_off + LW'(1);
                r_head        <= r_head + SW'(1);
            end
            if (w_release) r_tail <= r_tail + SW'(1);
            case ({w_commit, w_release})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_err_cnt <= bump(r_err_cnt, w_err_inc, w_clr);
            r_flt_cnt <= bump(r_flt_cnt, w_flt_inc, w_clr);
            r_ovf_cnt <= bump(r_ovf_cnt, w_ovf_inc, w_clr);
            if (w_wr && reg_addr == 3'd0) r_mac[31:0] <= reg_wdata;
            if (w_wr && reg_addr == 3'd1) begin
                r_irq_en     <= reg_wdata[31];
                r_promisc    <= reg_wdata[30];
                r_mac[47:32] <= reg_wdata[15:0];
            end
            r_rdata <= (reg_sel && !reg_we) ? w_rd : 32'h0;
            r_irq   <= r_irq_en && (r_count != '0);
        end
    end

    assign reg_rdata = r_rdata;
    assign irq       = r_irq;
endmodule

// File: tb/tb_eth_rx_ring.sv
// Bench for eth_rx_ring: directed steps plus random frames against a slot/queue-level ring model.
module tb_eth_rx_ring;
    localparam int          NBUF    = 8;
    localparam int          BUF_AW  = 11;
    localparam int          AW      = $clog2(NBUF) + BUF_AW;
    localparam logic [47:0] MAC_RST = 48'h230100890702;

    logic          msoc_clk = 1'b0;
    logic          rst_int;
    logic [7:0]    rx_tdata;
    logic          rx_tvalid, rx_tlast, rx_tuser;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          reg_sel, reg_we;
    logic [2:0]    reg_addr;
    logic [31:0]   reg_wdata, reg_rdata;
    logic          irq;

    always #5 msoc_clk = ~msoc_clk;

    eth_rx_ring #(.NBUF(NBUF), .BUF_AW(BUF_AW), .MAC_RESET(MAC_RST)) dut (
        .msoc_clk(msoc_clk), .rst_int(rst_int),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_sel(reg_sel), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .irq(irq)
    );

    int errors = 0;
    int checks = 0;

    int          m_head, m_tail, m_count, m_err, m_flt, m_ovf;
    logic [47:0] m_mac;
    bit          m_promisc, m_irq_en;
    int          m_lens[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_count = 0;
        m_err = 0; m_flt = 0; m_ovf = 0;
        m_mac = MAC_RST; m_promisc = 0; m_irq_en = 0;
        m_lens.delete();
    endtask

    task automatic model_release();
        if (m_count > 0) begin
            m_tail = (m_tail + 1) % NBUF;
            m_count--;
            void'(m_lens.pop_front());
        end
    endtask

    function automatic bit dst_accepted(input logic [47:0] dst);
        return m_promisc || dst == 48'hFFFF_FFFF_FFFF || dst[47:24] == 24'h01005E || dst == m_mac;
    endfunction

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge msoc_clk);
        reg_sel = 1; reg_we = 1; reg_addr = a; reg_wdata = d;
        @(posedge msoc_clk);
        #1;
        reg_sel = 0; reg_we = 0;
        case (a)
            3'd0: m_mac[31:0] = d;
            3'd1: begin m_irq_en = d[31]; m_promisc = d[30]; m_mac[47:32] = d[15:0]; end
            3'd3: model_release();
            3'd4: begin m_err = 0; m_flt = 0; m_ovf = 0; end
            default: ;
        endcase
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge msoc_clk);
        reg_sel = 1; reg_we = 0; reg_addr = a;
        @(posedge msoc_clk);
        #1;
        reg_sel = 0;
        @(negedge msoc_clk);
        d = reg_rdata;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        logic [15:0] len_exp;
        len_exp = 16'h0;
        if (m_count > 0) len_exp = 16'(m_lens[0]);
        reg_read(3'd2, d);
        chk({tag, "/reg2"}, d, {8'h0, 8'(m_count), 8'(m_head), 8'(m_tail)});
        reg_read(3'd4, d);
        chk({tag, "/reg4"}, d, {m_err[15:0], m_flt[15:0]});
        reg_read(3'd5, d);
        chk({tag, "/reg5"}, d, {m_ovf[15:0], len_exp});
        chk({tag, "/irq"}, irq, m_irq_en && m_count > 0);
    endtask

    // Drives one frame; checks every memory write lands at {slot, byte index} with the driven byte.
    task automatic send_frame(input logic [47:0] dst, input int len, input bit tuser,
                              input bit rel_at_last, input string tag);
        int nwr, bad, exp_wr, slot;
        bit full;
        logic [7:0] b;
        nwr = 0; bad = 0; slot = m_head; full = (m_count == NBUF);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge msoc_clk);
                rx_tvalid = 0;
                #1;
                if (mem_we) bad++;
            end
            b = (i < 6) ? dst[47-8*i -: 8] : 8'($urandom);
            @(negedge msoc_clk);
            rx_tvalid = 1; rx_tdata = b; rx_tlast = (i == len - 1);
            rx_tuser = (i == len - 1) && tuser;
            if (rel_at_last && i == len - 1) begin
                reg_sel = 1; reg_we = 1; reg_addr = 3'd3; reg_wdata = 0;
            end
            #1;
            if (mem_we) begin
                nwr++;
                if (int'(mem_addr) != slot * (1 << BUF_AW) + i || mem_wdata !== b) bad++;
            end
        end
        @(posedge msoc_clk);
        #1;
        rx_tvalid = 0; rx_tlast = 0; rx_tuser = 0; reg_sel = 0; reg_we = 0;
        if (rel_at_last) model_release();
        exp_wr = -1;
        if (full) begin
            m_ovf = sat(m_ovf); exp_wr = 0;
        end else if (len < 6) begin
            m_err = sat(m_err);
        end else if (!dst_accepted(dst)) begin
            m_flt = sat(m_flt);
        end else if (len > (1 << BUF_AW)) begin
            m_err = sat(m_err); exp_wr = 1 << BUF_AW;
        end else if (tuser) begin
            m_err = sat(m_err); exp_wr = len;
        end else begin
            exp_wr = len;
            m_lens.push_back(len);
            m_head = (m_head + 1) % NBUF;
            m_count++;
        end
        if (exp_wr >= 0) chk({tag, "/writes"}, nwr, exp_wr);
        chk({tag, "/bad_writes"}, bad, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [47:0] dst;
        int          len;
        bit          tu;

        rst_int = 1; rx_tvalid = 1; rx_tdata = 8'h5A; rx_tlast = 0; rx_tuser = 0;
        reg_sel = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0;
        model_reset();
        repeat (3) @(negedge msoc_clk);
        #1;
        chk("rst/mem_we", mem_we, 0);
        chk("rst/mem_addr", mem_addr, 0);
        chk("rst/mem_wdata", mem_wdata, 0);
        chk("rst/rdata", reg_rdata, 0);
        chk("rst/irq", irq, 0);
        @(negedge msoc_clk);
        rst_int = 0; rx_tvalid = 0;
        reg_read(3'd0, d); chk("rst/reg0", d, 32'h0089_0702);
        reg_read(3'd1, d); chk("rst/reg1", d, 32'h0000_2301);
        check_regs("rst");

        // 64-byte frame to the station address with interrupts enabled
        reg_write(3'd1, {1'b1, 1'b0, 14'h0, MAC_RST[47:32]});
        send_frame(MAC_RST, 64, 0, 0, "t1");
        reg_read(3'd2, d); chk("t1/reg2", d, 32'h0001_0100);
        reg_read(3'd5, d); chk("t1/len", d[11:0], 12'd64);
        chk("t1/irq", irq, 1);
        @(negedge msoc_clk); chk("t1/rdata_idle", reg_rdata, 0);
        reg_write(3'd3, 0);
        repeat (2) @(negedge msoc_clk);
        chk("t1/irq_off", irq, 0);

        // Destination filtering
        send_frame(48'h0200_0000_0001, 60, 0, 0, "flt");
        reg_read(3'd4, d); chk("t2/flt_cnt", d, 32'h0000_0001);
        reg_write(3'd1, {1'b1, 1'b1, 14'h0, MAC_RST[47:32]});
        send_frame(48'h0200_0000_0001, 60, 0, 0, "promisc");
        reg_write(3'd1, {1'b1, 1'b0, 14'h0, MAC_RST[47:32]});
        send_frame(48'hFFFF_FFFF_FFFF, 70, 0, 0, "bcast");
        send_frame({24'h01005E, 24'h7F0203}, 80, 0, 0, "mcast");
        check_regs("t2");

        // Random traffic mix
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0:       dst = m_mac;
                1:       dst = 48'hFFFF_FFFF_FFFF;
                2:       dst = {24'h01005E, 24'($urandom)};
                default: dst = {8'h02, 8'($urandom), 32'($urandom)};
            endcase
            len = $urandom_range(7, 120);
            tu  = ($urandom_range(0, 5) == 0);
            send_frame(dst, len, tu, $urandom_range(0, 3) == 0, "rand");
            if ($urandom_range(0, 2) == 0) reg_write(3'd3, 0);
            check_regs("rand");
        end

        // Ring full: ninth frame dropped whole, then wrap after one release
        while (m_count > 0) reg_write(3'd3, 0);
        reg_write(3'd4, 0);
        for (int k = 0; k < 9; k++) send_frame(m_mac, 30 + k, 0, 0, "fill");
        reg_read(3'd2, d); chk("t3/full_count", d[23:16], 8'd8);
        reg_read(3'd5, d); chk("t3/ovf_cnt", d[31:16], 16'd1);
        check_regs("t3");
        reg_write(3'd3, 0);
        send_frame(m_mac, 40, 0, 0, "wrap");
        check_regs("wrap");

        // Error frames
        while (m_count > 0) reg_write(3'd3, 0);
        reg_write(3'd4, 0);
        send_frame(m_mac, 50, 1, 0, "tuser");
        reg_read(3'd4, d); chk("t4/err1", d[31:16], 16'd1);
        send_frame(m_mac, 4, 0, 0, "runt");
        reg_read(3'd4, d); chk("t4/err2", d[31:16], 16'd2);
        send_frame(m_mac, (1 << BUF_AW) + 1, 0, 0, "long");
        reg_read(3'd4, d); chk("t4/err3", d[31:16], 16'd3);
        check_regs("t4");
        send_frame(m_mac, 1 << BUF_AW, 0, 0, "maxlen");
        check_regs("maxlen");

        // Release in the same cycle as a commit
        while (m_count > 0) reg_write(3'd3, 0);
        for (int k = 0; k < 3; k++) send_frame(m_mac, 20 + k, 0, 0, "pre");
        send_frame(m_mac, 25, 0, 1, "simul");
        reg_read(3'd2, d); chk("t5/count", d[23:16], 8'd3);
        check_regs("t5");
        while (m_count > 0) reg_write(3'd3, 0);
        reg_write(3'd3, 0);
        reg_read(3'd2, d); chk("t5/empty_count", d[23:16], 8'd0);
        check_regs("t5_empty");

        // Reset in the middle of a frame body
        send_frame(m_mac, 30, 0, 0, "pre_rst");
        repeat (2) @(negedge msoc_clk);
        chk("t6/irq_before", irq, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge msoc_clk);
            rx_tvalid = 1; rx_tlast = 0; rx_tdata = (i < 6) ? m_mac[47-8*i -: 8] : 8'(i);
        end
        @(negedge msoc_clk);
        rst_int = 1; rx_tdata = 8'hA5;
        #1;
        chk("t6/mem_we", mem_we, 0);
        chk("t6/mem_addr", mem_addr, 0);
        chk("t6/mem_wdata", mem_wdata, 0);
        chk("t6/irq", irq, 0);
        chk("t6/rdata", reg_rdata, 0);
        @(negedge msoc_clk);
        rst_int = 0; rx_tvalid = 0;
        model_reset();
        send_frame(MAC_RST, 100, 0, 0, "post_rst");
        reg_read(3'd5, d); chk("t6/len", d[15:0], 16'd100);
        reg_read(3'd2, d); chk("t6/reg2", d, 32'h0001_0100);
        check_regs("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
